// File: rtl/multiword_adder_seq.sv
// -----------------------------------------------------------------------------
// multiword_adder_seq
//
// Sequential multi-word adder/subtractor. Operands are NWORDS x 16-bit words
// wide. One 16-bit word is processed per clock, starting at word 0 and rippling
// the carry through a carry register. The result is published on s, c_out and
// overflow only when the last word finishes. These outputs hold their values
// until the next operation completes.
//
// Parameters
//   NWORDS    number of 16-bit words per operand (1..8)
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   start     request a new operation. Accepted only in IDLE or DONE.
//   sub       0: a + b + c_in, 1: a - b (c_in ignored). Latched with start.
//   a, b      operands, latched with start
//   c_in      carry into word 0, latched with start
//   s         registered result
//   c_out     registered carry out of the top word (sub: 1 = no borrow)
//   overflow  registered two's-complement overflow of the full-width result
//   busy      high while words are being processed (ADD state)
//   done      one-cycle completion pulse (DONE state)
// -----------------------------------------------------------------------------
module multiword_adder_seq #(
    parameter int NWORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sub,
    input  logic [16*NWORDS-1:0]   a,
    input  logic [16*NWORDS-1:0]   b,
    input  logic                   c_in,
    output logic [16*NWORDS-1:0]   s,
    output logic                   c_out,
    output logic                   overflow,
    output logic                   busy,
    output logic                   done
);

    localparam int W  = 16 * NWORDS;
    // The index must be able to hold NWORDS, because it is incremented
    // once more on the final ADD cycle.
    localparam int KW = $clog2(NWORDS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;

    logic [W-1:0]    a_reg, b_reg;
    logic            sub_reg;
    logic            carry_reg;
    logic [KW-1:0]   k_reg;
    logic [W-1:0]    partial_reg;
    logic [W-1:0]    partial_next;
    logic [W-1:0]    s_reg;
    logic            c_out_reg;
    logic            overflow_reg;

    logic [NWORDS-1:0] word_sel;
    logic [15:0]     a_cur, b_cur, b_eff;
    logic [16:0]     word_sum;
    logic            last_word;
    logic            load_op;
    logic            ovf_next;

    // One-hot decode of the word index. It is shared by the operand mux and
    // by the partial-result write enables.
    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_sel
            assign word_sel[gi] = (k_reg == KW'(gi));
        end
    endgenerate

    // Select the current operand words and form one 17-bit word sum.
    always_comb begin
        a_cur = '0;
        b_cur = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (word_sel[i]) begin
                a_cur = a_reg[i*16 +: 16];
                b_cur = b_reg[i*16 +: 16];
            end
        end
        // Subtraction is a + ~b + 1. The +1 comes from the preloaded carry.
        b_eff    = sub_reg ? ~b_cur : b_cur;
        word_sum = {1'b0, a_cur} + {1'b0, b_eff} + {16'd0, carry_reg};
    end

    // Partial result with the current word merged in. On the final ADD cycle
    // this value is the complete result that s loads.
    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_partial
            assign partial_next[gi*16 +: 16] =
                (state_reg == ST_ADD && word_sel[gi]) ? word_sum[15:0]
                                                      : partial_reg[gi*16 +: 16];
        end
    endgenerate

    assign last_word = (k_reg == KW'(NWORDS - 1));

    // Signed overflow: the operand signs agree (A and effective B), but the
    // sign of the result differs from them.
    always_comb begin
        logic bp_msb;
        bp_msb   = sub_reg ? ~b_reg[W-1] : b_reg[W-1];
        ovf_next = (a_reg[W-1] == bp_msb) && (partial_next[W-1] != a_reg[W-1]);
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        load_op    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_ADD;
                    load_op    = 1'b1;
                end
            end
            ST_ADD: begin
                if (last_word) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // Back-to-back: a start seen in DONE launches the next operation
                // with no IDLE cycle in between.
                if (start) begin
                    state_next = ST_ADD;
                    load_op    = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            sub_reg      <= 1'b0;
            carry_reg    <= 1'b0;
            k_reg        <= '0;
            partial_reg  <= '0;
            s_reg        <= '0;
            c_out_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load_op) begin
                a_reg     <= a;
                b_reg     <= b;
                sub_reg   <= sub;
                carry_reg <= sub ? 1'b1 : c_in;
                k_reg     <= '0;
            end else if (state_reg == ST_ADD) begin
                partial_reg <= partial_next;
                carry_reg   <= word_sum[16];
                k_reg       <= k_reg + KW'(1);
                if (last_word) begin
                    s_reg        <= partial_next;
                    c_out_reg    <= word_sum[16];
                    overflow_reg <= ovf_next;
                end
            end
        end
    end

    assign s        = s_reg;
    assign c_out    = c_out_reg;
    assign overflow = overflow_reg;
    assign busy     = (state_reg == ST_ADD);
    assign done     = (state_reg == ST_DONE);

endmodule

// File: tb/tb_multiword_adder_seq.sv
// -----------------------------------------------------------------------------
// tb_multiword_adder_seq
//
// Self-checking bench for multiword_adder_seq with NWORDS = 4.
// Stimulus comes from three sources:
//   - a directed vector table with fixed expected results
//   - random operations checked against a plain-arithmetic reference model
//   - hand-written sequences for reset abort and back-to-back starts
// -----------------------------------------------------------------------------
module tb_multiword_adder_seq;

    localparam int NW = 4;
    localparam int W  = 16 * NW;
    localparam logic signed [65:0] SMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [65:0] SMIN = -SMAX - 66'sd1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          sub;
    logic [W-1:0]  a, b;
    logic          c_in;
    logic [W-1:0]  s;
    logic          c_out, overflow, busy, done;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] last_s;
    logic         last_c, last_ov;

    always #5 clk = ~clk;

    multiword_adder_seq #(.NWORDS(NW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .s        (s),
        .c_out    (c_out),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    typedef struct {
        logic         sb;
        logic [63:0]  x;
        logic [63:0]  y;
        logic         ci;
        logic [63:0]  es;
        logic         ec;
        logic         eov;
    } vec_t;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // Reference model built from plain integer arithmetic.
    function automatic void model(input logic sb, input logic [63:0] x, input logic [63:0] y,
                                  input logic ci, output logic [63:0] rs,
                                  output logic rc, output logic rov);
        logic [64:0]        u;
        logic signed [65:0] t;
        if (sb) begin
            rs = x - y;
            rc = (x >= y);
            t  = $signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y});
        end else begin
            u  = {1'b0, x} + {1'b0, y} + {64'd0, ci};
            rs = u[63:0];
            rc = u[64];
            t  = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y}) + $signed({65'd0, ci});
        end
        rov = (t > SMAX) || (t < SMIN);
    endfunction

    // Pulse start for one cycle, wait for done, and check latency, busy length,
    // output hold during ADD, and the result. Operand inputs are scrambled once
    // start has been taken, to prove they were latched.
    task automatic run_op(input string tag, input logic sb, input logic [63:0] x,
                          input logic [63:0] y, input logic ci, input logic [63:0] es,
                          input logic ec, input logic eov);
        int n;
        int busy_cnt;
        logic held;
        sub   = sb;
        a     = x;
        b     = y;
        c_in  = ci;
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        a        = {$urandom(), $urandom()};
        b        = {$urandom(), $urandom()};
        sub      = ~sb;
        c_in     = ~ci;
        n        = 0;
        busy_cnt = 0;
        held     = 1'b1;
        while (!done && n < 20) begin
            if (busy) busy_cnt++;
            if (s !== last_s || c_out !== last_c || overflow !== last_ov) held = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check64({tag, "_latency"}, 64'(n), 64'(NW));
        check64({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(NW));
        check1({tag, "_hold_in_add"}, held, 1'b1);
        check64({tag, "_s"}, s, es);
        check1({tag, "_c_out"}, c_out, ec);
        check1({tag, "_overflow"}, overflow, eov);
        $display("op %s sub=%b a=%h b=%h cin=%b -> s=%h c=%b ov=%b lat=%0d",
                 tag, sb, x, y, ci, s, c_out, overflow, n);
        last_s  = es;
        last_c  = ec;
        last_ov = eov;
        @(posedge clk); #1;
        check1({tag, "_done_one_cycle"}, done, 1'b0);
    endtask

    function automatic logic [63:0] pick_operand();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            1:       v = 64'h7FFF_FFFF_FFFF_FFFF;
            2:       v = 64'h8000_0000_0000_0000;
            3:       v = {32'd0, $urandom()} & 64'h0000_0000_0000_FFFF;
            default: v = {$urandom(), $urandom()};
        endcase
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[9];
        logic [63:0] es;
        logic        ec, eov;
        logic        saw_done;
        logic [63:0] bx[5], by[5];
        logic        bs[5], bc[5];
        int          n;

        vecs[0] = '{1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 64'h5, 64'h7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 64'h7, 64'h5, 1'b0, 64'h2, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 64'hA, 64'h3, 1'b1, 64'h7, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0,
                    64'h0001_0000_0001_0000, 1'b0, 1'b0};

        // Reset, with start asserted to confirm that reset wins.
        rst   = 1'b1;
        start = 1'b1;
        sub   = 1'b0;
        a     = 64'h1234;
        b     = 64'h1;
        c_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check1("reset_busy", busy, 1'b0);
        check1("reset_done", done, 1'b0);
        check64("reset_s", s, 64'h0);
        check1("reset_c_out", c_out, 1'b0);
        check1("reset_overflow", overflow, 1'b0);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        last_s  = '0;
        last_c  = 1'b0;
        last_ov = 1'b0;

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].sb, vecs[i].x, vecs[i].y, vecs[i].ci,
                   vecs[i].es, vecs[i].ec, vecs[i].eov);
        end

        // Randomized operations against the reference model
        for (int i = 0; i < 30; i++) begin
            logic [63:0] x, y;
            logic sb, ci;
            x  = pick_operand();
            y  = pick_operand();
            sb = 1'($urandom_range(0, 1));
            ci = 1'($urandom_range(0, 1));
            model(sb, x, y, ci, es, ec, eov);
            run_op($sformatf("rnd%0d", i), sb, x, y, ci, es, ec, eov);
        end

        // Reset during the second ADD cycle aborts the operation.
        sub   = 1'b0;
        a     = 64'hFFFF_FFFF_FFFF_FFFF;
        b     = 64'h1;
        c_in  = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check1("abort_busy", busy, 1'b0);
        check64("abort_s", s, 64'h0);
        check1("abort_c_out", c_out, 1'b0);
        check1("abort_overflow", overflow, 1'b0);
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        check1("abort_no_done", saw_done, 1'b0);
        $display("op abort rst in second ADD cycle -> busy=%b s=%h done_seen=%b", busy, s, saw_done);
        last_s  = '0;
        last_c  = 1'b0;
        last_ov = 1'b0;
        model(1'b0, 64'h0000_1111_2222_3333, 64'h0000_0000_0000_CCCD, 1'b0, es, ec, eov);
        run_op("after_abort", 1'b0, 64'h0000_1111_2222_3333, 64'h0000_0000_0000_CCCD, 1'b0,
               es, ec, eov);

        // Back-to-back: start stays high. The operand inputs switch to the next
        // set immediately after each launch.
        for (int i = 0; i < 5; i++) begin
            bx[i] = pick_operand();
            by[i] = pick_operand();
            bs[i] = 1'($urandom_range(0, 1));
            bc[i] = 1'($urandom_range(0, 1));
        end
        sub   = bs[0];
        a     = bx[0];
        b     = by[0];
        c_in  = bc[0];
        start = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                sub  = bs[i+1];
                a    = bx[i+1];
                b    = by[i+1];
                c_in = bc[i+1];
            end else begin
                start = 1'b0;
            end
            check1($sformatf("b2b%0d_busy_at_launch", i), busy, 1'b1);
            n = 0;
            while (!done && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            model(bs[i], bx[i], by[i], bc[i], es, ec, eov);
            check64($sformatf("b2b%0d_latency", i), 64'(n), 64'(NW));
            check64($sformatf("b2b%0d_s", i), s, es);
            check1($sformatf("b2b%0d_c_out", i), c_out, ec);
            check1($sformatf("b2b%0d_overflow", i), overflow, eov);
            $display("op b2b%0d sub=%b a=%h b=%h cin=%b -> s=%h c=%b ov=%b lat=%0d",
                     i, bs[i], bx[i], by[i], bc[i], s, c_out, overflow, n);
            @(posedge clk); #1;
        end
        check1("b2b_final_idle_busy", busy, 1'b0);
        check1("b2b_final_idle_done", done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
